// File: rtl/ay_psg_pkg.sv
// ---------------------------------------------------------------------------
// ay_psg_pkg : shared AY PSG constants, envelope shape bits and state type
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ay_psg_pkg;

  // Bit positions inside R13[3:0]
  localparam int SHAPE_CONTINUE  = 3;
  localparam int SHAPE_ATTACK    = 2;
  localparam int SHAPE_ALTERNATE = 1;
  localparam int SHAPE_HOLD      = 0;

  localparam int ENV_MAX_LEVEL   = 15;

  typedef enum logic [0:0] {
    ENV_HOLD = 1'b0,
    ENV_RUN  = 1'b1
  } env_state_t;

endpackage

`default_nettype wire

// File: rtl/ay_envelope_step_timer.sv
// ---------------------------------------------------------------------------
// ay_envelope_step_timer : free-running prescaler plus period counter that
//                          emits a one-cycle step strobe
// Revision               : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ay_envelope_step_timer #(
  parameter int PERIOD_BITS   = 16,
  parameter int PRESCALE_BITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [PERIOD_BITS-1:0] period,
  output logic                   step_strobe
);

  logic                   w_tick;
  logic [PERIOD_BITS-1:0] r_cnt;
  logic [PERIOD_BITS:0]   w_cnt_inc;
  logic [PERIOD_BITS:0]   w_limit;
  logic                   w_step_end;

  generate
    if (PRESCALE_BITS == 0) begin : g_no_prescale
      assign w_tick = 1'b1;
    end else begin : g_prescale
      logic [PRESCALE_BITS-1:0] r_pre;

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          r_pre <= '0;
        end else begin
          r_pre <= r_pre + 1'b1;
        end
      end

      // Tick on the cycle whose edge wraps the prescaler back to zero
      assign w_tick = &r_pre;
    end
  endgenerate

  // A zero period behaves as one; >= lets a shrunk period end the step early
  assign w_limit     = (period == '0) ? {{PERIOD_BITS{1'b0}}, 1'b1} : {1'b0, period};
  assign w_cnt_inc   = {1'b0, r_cnt} + 1'b1;
  assign w_step_end  = (w_cnt_inc >= w_limit);
  assign step_strobe = enable & w_tick & w_step_end & ~clear;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (enable && w_tick) begin
      if (w_step_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_inc[PERIOD_BITS-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ay_envelope_generator.sv
// ---------------------------------------------------------------------------
// ay_envelope_generator : AY-3-8913 shared envelope level generator (R11-R13)
//                         Option macro: AY_ENVELOPE_YM2149_32STEP_EN
// Revision              : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ay_envelope_generator
  import ay_psg_pkg::*;
#(
  parameter int PERIOD_BITS   = 16,
  parameter int PRESCALE_BITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic [3:0]             shape,
  input  logic                   restart,
  output logic [3:0]             envelope,
`ifdef AY_ENVELOPE_YM2149_32STEP_EN
  output logic [4:0]             envelope_fine,
`endif
  output logic                   holding
);

`ifdef AY_ENVELOPE_YM2149_32STEP_EN
  localparam int STEP_BITS      = 5;
  localparam int C_STEP_MAX_INT = 2 * ENV_MAX_LEVEL + 1;
`else
  localparam int STEP_BITS      = 4;
  localparam int C_STEP_MAX_INT = ENV_MAX_LEVEL;
`endif
  localparam logic [STEP_BITS-1:0] c_STEP_MAX = STEP_BITS'(C_STEP_MAX_INT);

  env_state_t           r_state, w_state_nxt;
  logic [STEP_BITS-1:0] r_step,  w_step_nxt;
  logic                 r_invert, w_invert_nxt;
  logic [STEP_BITS-1:0] r_held,  w_held_nxt;
  logic [STEP_BITS-1:0] r_env;
  logic [STEP_BITS-1:0] w_level;
  logic                 w_step_strobe;
  logic                 w_run;

  assign w_run = (r_state == ENV_RUN);

  ay_envelope_step_timer #(
    .PERIOD_BITS   (PERIOD_BITS),
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_step_timer (
    .clk         (clk),
    .reset       (reset),
    .clear       (restart),
    .enable      (w_run),
    .period      (period),
    .step_strobe (w_step_strobe)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_step_nxt   = r_step;
    w_invert_nxt = r_invert;
    w_held_nxt   = r_held;
    if (restart) begin
      w_state_nxt  = ENV_RUN;
      w_step_nxt   = '0;
      w_invert_nxt = 1'b0;
    end else if (w_run && w_step_strobe) begin
      if (r_step == c_STEP_MAX) begin
        if (!shape[SHAPE_CONTINUE]) begin
          w_state_nxt = ENV_HOLD;
          w_held_nxt  = '0;
        end else if (shape[SHAPE_HOLD]) begin
          w_state_nxt = ENV_HOLD;
          w_held_nxt  = (shape[SHAPE_ATTACK] ^ shape[SHAPE_ALTERNATE]) ? c_STEP_MAX : '0;
        end else begin
          w_step_nxt   = '0;
          w_invert_nxt = r_invert ^ shape[SHAPE_ALTERNATE];
        end
      end else begin
        w_step_nxt = r_step + 1'b1;
      end
    end
  end

  // Shape is read live so an un-restarted R13 write bends the current ramp
  assign w_level = w_run ? ((shape[SHAPE_ATTACK] ^ r_invert) ? r_step : (c_STEP_MAX - r_step))
                         : r_held;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ENV_HOLD;
      r_step   <= '0;
      r_invert <= 1'b0;
      r_held   <= '0;
      r_env    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_step   <= w_step_nxt;
      r_invert <= w_invert_nxt;
      r_held   <= w_held_nxt;
      // Restart shows the first level immediately rather than after the pipeline
      if (restart) begin
        r_env <= shape[SHAPE_ATTACK] ? '0 : c_STEP_MAX;
      end else begin
        r_env <= w_level;
      end
    end
  end

  assign envelope = r_env[STEP_BITS-1 -: 4];
`ifdef AY_ENVELOPE_YM2149_32STEP_EN
  assign envelope_fine = r_env;
`endif
  assign holding  = (r_state == ENV_HOLD);

endmodule

`default_nettype wire

// File: tb/tb_ay_envelope_generator.sv
// ---------------------------------------------------------------------------
// tb_ay_envelope_generator : scoreboard bench for ay_envelope_generator
// Revision                 : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ay_envelope_generator;

  localparam int PERIOD_BITS   = 16;
  localparam int PRESCALE_BITS = 2;
  localparam int CLK_PER_TICK  = 4;

  logic                   clk;
  logic                   reset;
  logic [PERIOD_BITS-1:0] period;
  logic [3:0]             shape;
  logic                   restart;
  logic [3:0]             envelope;
  logic                   holding;
`ifdef AY_ENVELOPE_YM2149_32STEP_EN
  logic [4:0]             envelope_fine;
`endif

  ay_envelope_generator #(
    .PERIOD_BITS   (PERIOD_BITS),
    .PRESCALE_BITS (PRESCALE_BITS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .period        (period),
    .shape         (shape),
    .restart       (restart),
    .envelope      (envelope),
`ifdef AY_ENVELOPE_YM2149_32STEP_EN
    .envelope_fine (envelope_fine),
`endif
    .holding       (holding)
  );

  typedef struct {
    int         cyc;
    int         tid;
    int         j;
    logic [3:0] env;
    logic       hold;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: compare every expectation due at this sampling point
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      e = sb.pop_front();
      n_checks++;
      if (e.cyc < edge_cnt) begin
        n_fail++;
        $display("FAIL test%0d missed j=%0d: expectation at cycle %0d not sampled (now %0d)",
                 e.tid, e.j, e.cyc, edge_cnt);
      end else if (envelope !== e.env || holding !== e.hold) begin
        n_fail++;
        $display("FAIL test%0d j=%0d cyc=%0d: envelope=%0d holding=%0b, expected envelope=%0d holding=%0b",
                 e.tid, e.j, e.cyc, envelope, holding, e.env, e.hold);
      end
    end
  end

  // Reference waveform for step number n since restart
  function automatic logic [3:0] ref_level(input logic [3:0] sh, input int n);
    int   c;
    int   s;
    logic up;
    c = n / 16;
    s = n % 16;
    if (n >= 16 && (!sh[3] || sh[0])) begin
      if (!sh[3]) return 4'd0;
      return (sh[2] ^ sh[1]) ? 4'd15 : 4'd0;
    end
    up = sh[2] ^ (sh[1] & c[0]);
    return up ? 4'(s) : 4'(15 - s);
  endfunction

  task automatic idle_check(input int tid, input int n);
    exp_t e;
    for (int j = 1; j <= n; j++) begin
      e.cyc = edge_cnt + j; e.tid = tid; e.j = j; e.env = 4'd0; e.hold = 1'b1;
      sb.push_back(e);
    end
    repeat (n) @(negedge clk);
  endtask

  // Issue restart at the current negedge and expect n observations afterwards
  task automatic run_shape(input int tid, input logic [3:0] sh, input int p, input int n);
    exp_t e;
    int   pe;
    int   k;
    pe      = (p == 0) ? 1 : p;
    period  = PERIOD_BITS'(p);
    shape   = sh;
    restart = 1'b1;
    k       = edge_cnt;
    for (int j = 0; j < n; j++) begin
      e.cyc  = k + 1 + j;
      e.tid  = tid;
      e.j    = j;
      e.env  = ref_level(sh, (j == 0) ? 0 : (j - 1) / (CLK_PER_TICK * pe));
      e.hold = (!sh[3] || sh[0]) && ((j / (CLK_PER_TICK * pe)) >= 16);
      sb.push_back(e);
    end
    @(negedge clk);
    restart = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   guard;
    reset   = 1'b1;
    restart = 1'b0;
    shape   = 4'h0;
    period  = '0;
    repeat (3) @(negedge clk);
    e.cyc = edge_cnt + 1; e.tid = 0; e.j = 0; e.env = 4'd0; e.hold = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    reset  = 1'b0;
    shape  = 4'hD;
    period = PERIOD_BITS'(1);

    idle_check(1, 1000);
    run_shape(2, 4'hD, 1, 90);
    run_shape(3, 4'hE, 2, 820);
    run_shape(4, 4'h0, 1, 80);
    run_shape(5, 4'h0, 1, 27);
    run_shape(6, 4'h0, 1, 30);
    run_shape(7, 4'h8, 0, 140);
    run_shape(8, 4'h8, 1, 140);
    run_shape(9, 4'hC, 1, 64);
    run_shape(10, 4'hC, 1, 20);

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
